// File: rtl/debug_scan_pkg.sv
// Shared types and default sizes for the virtual-JTAG debug scan master.
package debug_scan_pkg;

   // Default scan geometry of the Nios II debug slave
   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;

   // Scan sequencer states, in the order one scan walks through them
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UIR  = 3'd1,
      CDR  = 3'd2,
      SDR  = 3'd3,
      UDR  = 3'd4,
      RTI  = 3'd5,
      RESP = 3'd6
   } scan_state_t;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// Test-clock generator: divides clk into tck periods of 2*TCK_DIV cycles
// while run is high and flags the rising edge and the last cycle of each period.
module debug_scan_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tck,
   output logic rise_stb,
   output logic end_stb
);

   localparam int CNT_W = $clog2(2 * TCK_DIV + 1);

   logic [CNT_W-1:0] div_cnt_reg;

   // tck is low for the first half of the period, high for the second
   assign tck      = (div_cnt_reg >= CNT_W'(TCK_DIV));
   assign rise_stb = (div_cnt_reg == CNT_W'(TCK_DIV));
   assign end_stb  = (div_cnt_reg == CNT_W'(2 * TCK_DIV - 1));

   // Period counter; parked at 0 whenever the sequencer is not running
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_reg <= '0;
      end else if (!run || end_stb) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/debug_scan_master.sv
// Initiator for the Nios II debug-slave virtual-JTAG link: takes an IR/DR
// command, walks the slave through UIR, CDR, SDR, UDR, RTI and returns the
// captured DR word and the IR status on a valid/ready response.
module debug_scan_master
   import debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_rti,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_uir
);

   localparam int BIT_W = $clog2(DR_WIDTH + 1);

   scan_state_t         state_reg, state_next;
   logic [DR_WIDTH-1:0] sr_reg, sr_next;
   logic                tbit_reg, tbit_next;
   logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [IR_WIDTH-1:0] ir_in_reg, ir_in_next;
   logic [IR_WIDTH-1:0] ir_out_reg, ir_out_next;
   logic                rsp_valid_reg, rsp_valid_next;
   logic [DR_WIDTH-1:0] rsp_dr_reg, rsp_dr_next;
   logic                tdi_reg, tdi_next;
   logic                rti_reg, rti_next;
   logic                cdr_reg, cdr_next;
   logic                sdr_reg, sdr_next;
   logic                udr_reg, udr_next;
   logic                uir_reg, uir_next;

   logic                tck_run;
   logic                tck_rise;
   logic                tck_end;
   logic                shift_bit;
   logic [DR_WIDTH:0]   shift_cat;

   // With TCK_DIV=1 the rise and end strobes coincide, so take tdo directly
   assign shift_bit = tck_rise ? vji_tdo : tbit_reg;
   assign shift_cat = {shift_bit, sr_reg};

   // Stop the divider one cycle early when leaving RESP so IDLE starts with tck low
   assign tck_run   = (state_reg != IDLE) && (state_next != IDLE);

   debug_scan_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk      (clk),
      .reset    (reset),
      .run      (tck_run),
      .tck      (vji_tck),
      .rise_stb (tck_rise),
      .end_stb  (tck_end)
   );

   assign cmd_ready  = (state_reg == IDLE) && !rsp_valid_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_dr     = rsp_dr_reg;
   assign rsp_ir_out = ir_out_reg;
   assign vji_tdi    = tdi_reg;
   assign vji_ir_in  = ir_in_reg;
   assign vji_rti    = rti_reg;
   assign vji_cdr    = cdr_reg;
   assign vji_sdr    = sdr_reg;
   assign vji_udr    = udr_reg;
   assign vji_uir    = uir_reg;

   // Next-state, datapath and registered-flag decode for the scan sequence
   always_comb begin
      state_next     = state_reg;
      sr_next        = sr_reg;
      tbit_next      = tbit_reg;
      bit_cnt_next   = bit_cnt_reg;
      ir_in_next     = ir_in_reg;
      ir_out_next    = ir_out_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_dr_next    = rsp_dr_reg;

      case (state_reg)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               sr_next      = cmd_dr;
               ir_in_next   = cmd_ir;
               bit_cnt_next = '0;
               state_next   = UIR;
            end
         end
         UIR: begin
            if (tck_rise) begin
               ir_out_next = vji_ir_out;
            end
            if (tck_end) begin
               state_next = CDR;
            end
         end
         CDR: begin
            if (tck_end) begin
               bit_cnt_next = '0;
               state_next   = SDR;
            end
         end
         SDR: begin
            if (tck_rise) begin
               tbit_next = vji_tdo;
            end
            if (tck_end) begin
               sr_next = shift_cat[DR_WIDTH:1];
               if (bit_cnt_reg == BIT_W'(DR_WIDTH - 1)) begin
                  state_next = UDR;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         UDR: begin
            if (tck_end) begin
               state_next = RTI;
            end
         end
         RTI: begin
            if (tck_end) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (!rsp_valid_reg) begin
               rsp_valid_next = 1'b1;
               rsp_dr_next    = sr_reg;
            end else if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Flags follow the state being entered so they line up with it exactly
      uir_next = (state_next == UIR);
      cdr_next = (state_next == CDR);
      sdr_next = (state_next == SDR);
      udr_next = (state_next == UDR);
      rti_next = (state_next == IDLE) || (state_next == RTI);
      tdi_next = (state_next == SDR) ? sr_next[0] : 1'b0;
   end

   // State and output registers; reset drops any scan in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         sr_reg        <= '0;
         tbit_reg      <= 1'b0;
         bit_cnt_reg   <= '0;
         ir_in_reg     <= '0;
         ir_out_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_dr_reg    <= '0;
         tdi_reg       <= 1'b0;
         rti_reg       <= 1'b0;
         cdr_reg       <= 1'b0;
         sdr_reg       <= 1'b0;
         udr_reg       <= 1'b0;
         uir_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sr_reg        <= sr_next;
         tbit_reg      <= tbit_next;
         bit_cnt_reg   <= bit_cnt_next;
         ir_in_reg     <= ir_in_next;
         ir_out_reg    <= ir_out_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_dr_reg    <= rsp_dr_next;
         tdi_reg       <= tdi_next;
         rti_reg       <= rti_next;
         cdr_reg       <= cdr_next;
         sdr_reg       <= sdr_next;
         udr_reg       <= udr_next;
         uir_reg       <= uir_next;
      end
   end

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master: default instance (TCK_DIV=2) plus a
// TCK_DIV=1 instance; one task per scenario with hand-computed expectations.
module tb_debug_scan_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Default instance
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_dr;
   logic        rsp_valid, rsp_ready;
   logic [37:0] rsp_dr;
   logic [1:0]  rsp_ir_out;
   logic        vji_tck, vji_tdi, vji_tdo;
   logic [1:0]  vji_ir_in, vji_ir_out;
   logic        vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir;
   logic        loopback, tdo_const;

   assign vji_tdo = loopback ? vji_tdi : tdo_const;

   debug_scan_master u_dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ir     (cmd_ir),
      .cmd_dr     (cmd_dr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_dr     (rsp_dr),
      .rsp_ir_out (rsp_ir_out),
      .vji_tck    (vji_tck),
      .vji_tdi    (vji_tdi),
      .vji_tdo    (vji_tdo),
      .vji_ir_in  (vji_ir_in),
      .vji_ir_out (vji_ir_out),
      .vji_rti    (vji_rti),
      .vji_cdr    (vji_cdr),
      .vji_sdr    (vji_sdr),
      .vji_udr    (vji_udr),
      .vji_uir    (vji_uir)
   );

   // TCK_DIV=1 instance, always in loopback
   logic        cmd_valid_1, cmd_ready_1;
   logic [1:0]  cmd_ir_1;
   logic [37:0] cmd_dr_1;
   logic        rsp_valid_1, rsp_ready_1;
   logic [37:0] rsp_dr_1;
   logic [1:0]  rsp_ir_out_1;
   logic        vji_tck_1, vji_tdi_1, vji_tdo_1;
   logic [1:0]  vji_ir_in_1, vji_ir_out_1;
   logic        vji_rti_1, vji_cdr_1, vji_sdr_1, vji_udr_1, vji_uir_1;

   assign vji_tdo_1 = vji_tdi_1;

   debug_scan_master #(.TCK_DIV(1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid_1),
      .cmd_ready  (cmd_ready_1),
      .cmd_ir     (cmd_ir_1),
      .cmd_dr     (cmd_dr_1),
      .rsp_valid  (rsp_valid_1),
      .rsp_ready  (rsp_ready_1),
      .rsp_dr     (rsp_dr_1),
      .rsp_ir_out (rsp_ir_out_1),
      .vji_tck    (vji_tck_1),
      .vji_tdi    (vji_tdi_1),
      .vji_tdo    (vji_tdo_1),
      .vji_ir_in  (vji_ir_in_1),
      .vji_ir_out (vji_ir_out_1),
      .vji_rti    (vji_rti_1),
      .vji_cdr    (vji_cdr_1),
      .vji_sdr    (vji_sdr_1),
      .vji_udr    (vji_udr_1),
      .vji_uir    (vji_uir_1)
   );

   int checks = 0;
   int passes = 0;

   // Issue one command on the default instance and run until rsp_valid is seen
   // (returns at that negedge). lat is cycles from the accept edge, -1 on timeout.
   task automatic do_scan(input logic [1:0] ir, input logic [37:0] dr,
                          output int lat, output int n_uir, output int n_cdr,
                          output int n_sdr, output int n_udr, output int n_rise,
                          output int n_overlap, output int n_tdi_out);
      int n;
      int k;
      logic prev_tck;
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
      n_rise = 0; n_overlap = 0; n_tdi_out = 0;
      @(negedge clk);
      cmd_ir    = ir;
      cmd_dr    = dr;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      prev_tck = 1'b0;
      while (n < 400) begin
         if (rsp_valid) break;
         if (vji_uir) n_uir++;
         if (vji_cdr) n_cdr++;
         if (vji_sdr) n_sdr++;
         if (vji_udr) n_udr++;
         if (vji_sdr && vji_tck && !prev_tck) n_rise++;
         if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr)) > 1) n_overlap++;
         if (!vji_sdr && vji_tdi) n_tdi_out++;
         prev_tck = vji_tck;
         @(negedge clk);
         n++;
      end
      lat = rsp_valid ? n : -1;
      $display("scan ir=%b dr=%h -> rsp_dr=%h ir_out=%b latency=%0d", ir, dr, rsp_dr, rsp_ir_out, lat);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      else passes++;
      checks++;
      if ({vji_tck, vji_tdi, vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_ir_in} !== 9'd0)
         $display("FAIL reset_vji_outputs: got %b expected 0",
                  {vji_tck, vji_tdi, vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_ir_in});
      else passes++;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      else passes++;
      checks++;
      if (vji_rti !== 1'b1) $display("FAIL idle_rti: got %b expected 1", vji_rti);
      else passes++;
   endtask

   task automatic finish_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_loopback();
      int lat, a, b, c, d, e, f, g;
      loopback = 1'b1;
      do_scan(2'b01, 38'h2A_5555_5555, lat, a, b, c, d, e, f, g);
      checks++;
      if (lat != 169) $display("FAIL loopback_latency: got %0d expected 169", lat);
      else passes++;
      checks++;
      if (rsp_dr !== 38'h2A_5555_5555) $display("FAIL loopback_rsp_dr: got %h expected 2a55555555", rsp_dr);
      else passes++;
      checks++;
      if (vji_ir_in !== 2'b01) $display("FAIL loopback_ir_in: got %b expected 01", vji_ir_in);
      else passes++;
      finish_rsp();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL loopback_handshake: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, cmd_ready);
      else passes++;
   endtask

   task automatic test_tdo_ones();
      int lat, a, b, c, d, e, f, g;
      loopback   = 1'b0;
      tdo_const  = 1'b1;
      vji_ir_out = 2'b10;
      do_scan(2'b11, 38'h0, lat, a, b, c, d, e, f, g);
      checks++;
      if (rsp_dr !== 38'h3F_FFFF_FFFF) $display("FAIL ones_rsp_dr: got %h expected 3fffffffff", rsp_dr);
      else passes++;
      checks++;
      if (rsp_ir_out !== 2'b10) $display("FAIL ones_rsp_ir_out: got %b expected 10", rsp_ir_out);
      else passes++;
      checks++;
      if (vji_ir_in !== 2'b11) $display("FAIL ones_ir_in: got %b expected 11", vji_ir_in);
      else passes++;
      finish_rsp();
      vji_ir_out = 2'b00;
      tdo_const  = 1'b0;
      loopback   = 1'b1;
   endtask

   task automatic test_flag_widths();
      int lat, n_uir, n_cdr, n_sdr, n_udr, n_rise, n_ovl, n_tdi;
      loopback = 1'b1;
      do_scan(2'b10, 38'h15_A5A5_3C3C, lat, n_uir, n_cdr, n_sdr, n_udr, n_rise, n_ovl, n_tdi);
      checks++;
      if (n_uir != 4 || n_cdr != 4 || n_udr != 4)
         $display("FAIL flag_widths_uir_cdr_udr: got %0d/%0d/%0d expected 4/4/4", n_uir, n_cdr, n_udr);
      else passes++;
      checks++;
      if (n_sdr != 152) $display("FAIL flag_width_sdr: got %0d expected 152", n_sdr);
      else passes++;
      checks++;
      if (n_rise != 38) $display("FAIL sdr_tck_rises: got %0d expected 38", n_rise);
      else passes++;
      checks++;
      if (n_ovl != 0 || n_tdi != 0)
         $display("FAIL flag_exclusive_tdi_quiet: got overlap=%0d tdi_outside=%0d expected 0/0", n_ovl, n_tdi);
      else passes++;
      checks++;
      if (rsp_dr !== 38'h15_A5A5_3C3C) $display("FAIL flag_rsp_dr: got %h expected 15a5a53c3c", rsp_dr);
      else passes++;
      finish_rsp();
   endtask

   task automatic test_backpressure();
      int lat, a, b, c, d, e, f, g;
      int drop, unstable, ready_hi, k, uir_seen;
      loopback = 1'b1;
      do_scan(2'b01, 38'h0F_1234_5678, lat, a, b, c, d, e, f, g);
      drop = 0; unstable = 0; ready_hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            cmd_valid = 1'b1;
            cmd_ir    = 2'b10;
            cmd_dr    = 38'h3C_0000_0001;
         end
         if (i == 6) cmd_valid = 1'b0;
         if (rsp_valid !== 1'b1) drop++;
         if (rsp_dr !== 38'h0F_1234_5678) unstable++;
         if (cmd_ready !== 1'b0) ready_hi++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checks++;
      if (drop != 0) $display("FAIL hold_rsp_valid: got %0d low cycles expected 0", drop);
      else passes++;
      checks++;
      if (unstable != 0) $display("FAIL hold_rsp_dr: got %0d changed cycles expected 0", unstable);
      else passes++;
      checks++;
      if (ready_hi != 0) $display("FAIL hold_cmd_ready: got %0d high cycles expected 0", ready_hi);
      else passes++;
      finish_rsp();
      uir_seen = 0;
      for (k = 0; k < 10; k++) begin
         if (vji_uir) uir_seen++;
         @(negedge clk);
      end
      checks++;
      if (uir_seen != 0 || vji_ir_in !== 2'b01)
         $display("FAIL busy_cmd_ignored: got uir_cycles=%0d ir_in=%b expected 0 and 01", uir_seen, vji_ir_in);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int lat, a, b, c, d, e, f, g;
      loopback  = 1'b1;
      rsp_ready = 1'b1;
      do_scan(2'b01, 38'h3F_0000_FFFF, lat, a, b, c, d, e, f, g);
      checks++;
      if (lat != 169 || rsp_dr !== 38'h3F_0000_FFFF)
         $display("FAIL b2b_first: got lat=%0d dr=%h expected 169 3f0000ffff", lat, rsp_dr);
      else passes++;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL one_cycle_rsp: got valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
      else passes++;
      do_scan(2'b10, 38'h00_FFFF_0000, lat, a, b, c, d, e, f, g);
      checks++;
      if (lat != 169 || rsp_dr !== 38'h00_FFFF_0000)
         $display("FAIL b2b_second: got lat=%0d dr=%h expected 169 00ffff0000", lat, rsp_dr);
      else passes++;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      int lat, a, b, c, d, e, f, g;
      int n, rises, spurious;
      logic prev_tck;
      loopback = 1'b1;
      @(negedge clk);
      cmd_ir = 2'b11; cmd_dr = 38'h2A_AAAA_AAAA; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0; rises = 0; prev_tck = 1'b0;
      while (n < 400 && rises < 11) begin
         if (vji_sdr && vji_tck && !prev_tck) rises++;
         prev_tck = vji_tck;
         if (rises < 11) begin
            @(negedge clk);
            n++;
         end
      end
      checks++;
      if (rises != 11) $display("FAIL midscan_reach_bit10: got %0d rises expected 11", rises);
      else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({vji_tck, vji_tdi, vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_ir_in} !== 9'd0)
         $display("FAIL midscan_vji_cleared: got %b expected 0",
                  {vji_tck, vji_tdi, vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_ir_in});
      else passes++;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL midscan_idle: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
      else passes++;
      reset = 1'b0;
      spurious = 0;
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid) spurious++;
         @(negedge clk);
      end
      checks++;
      if (spurious != 0) $display("FAIL midscan_no_rsp: got %0d valid cycles expected 0", spurious);
      else passes++;
      do_scan(2'b01, 38'h12_3456_789A, lat, a, b, c, d, e, f, g);
      checks++;
      if (lat != 169 || rsp_dr !== 38'h12_3456_789A)
         $display("FAIL midscan_fresh_cmd: got lat=%0d dr=%h expected 169 123456789a", lat, rsp_dr);
      else passes++;
      finish_rsp();
   endtask

   task automatic test_tck_div1();
      int n, bad_tck, lat;
      @(negedge clk);
      cmd_ir_1 = 2'b01; cmd_dr_1 = 38'h00_0000_0001; cmd_valid_1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid_1 = 1'b0;
      n = 0; bad_tck = 0;
      while (n < 300) begin
         if (rsp_valid_1) break;
         if (vji_tck_1 !== n[0]) bad_tck++;
         @(negedge clk);
         n++;
      end
      lat = rsp_valid_1 ? n : -1;
      $display("scan div1 ir=01 dr=%h -> rsp_dr=%h latency=%0d", cmd_dr_1, rsp_dr_1, lat);
      checks++;
      if (lat != 85) $display("FAIL div1_latency: got %0d expected 85", lat);
      else passes++;
      checks++;
      if (rsp_dr_1 !== 38'h00_0000_0001) $display("FAIL div1_rsp_dr: got %h expected 0000000001", rsp_dr_1);
      else passes++;
      checks++;
      if (bad_tck != 0) $display("FAIL div1_tck_toggle: got %0d bad cycles expected 0", bad_tck);
      else passes++;
      @(negedge clk);
      rsp_ready_1 = 1'b1;
      @(negedge clk);
      rsp_ready_1 = 1'b0;
      checks++;
      if (rsp_valid_1 !== 1'b0 || cmd_ready_1 !== 1'b1)
         $display("FAIL div1_handshake: got valid=%b ready=%b expected 0 1", rsp_valid_1, cmd_ready_1);
      else passes++;
   endtask

   initial begin
      reset       = 1'b1;
      cmd_valid   = 1'b0; cmd_ir   = '0; cmd_dr   = '0; rsp_ready   = 1'b0;
      cmd_valid_1 = 1'b0; cmd_ir_1 = '0; cmd_dr_1 = '0; rsp_ready_1 = 1'b0;
      vji_ir_out  = '0;   vji_ir_out_1 = '0;
      loopback    = 1'b1; tdo_const = 1'b0;

      test_reset();
      test_loopback();
      test_tdo_ones();
      test_flag_widths();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_scan();
      test_tck_div1();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
